// File: rtl/id_branch_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage branch hazard controller.
package id_branch_hazard_ctrl_pkg;

    // Instruction class presented by the decoder (6 and 7 behave as NONE)
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_REG    = 2'b11
    } pcsrc_e;

    // ID comparator operand select
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_WB    = 2'b01,
        FWD_EXOUT = 2'b10,
        FWD_ZERO  = 2'b11
    } fwd_e;

    // Controller state: HOLD covers the second bubble of a load feeding a branch
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/id_branch_hazard_ctrl_hazard_need_calc.sv
// Number of stall cycles one ID source register still needs before its
// value can be delivered to the consumer (0, 1 or 2).
module hazard_need_calc #(
    parameter int REG_AW = 5
) (
    input  logic              src_read,
    input  logic              branch_consumer,
    input  logic [REG_AW-1:0] src,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        need
);

    logic ex_hit;
    logic mem_load_hit;

    assign ex_hit       = ex_regwrite && (ex_rd == src);
    assign mem_load_hit = mem_regwrite && mem_memread && (mem_rd == src);

    // Branch compares happen in ID, so anything still in EX (and a load in MEM)
    // is too late; ordinary consumers only wait on a load in EX.
    always_comb begin
        need = 2'd0;
        if (src_read && (src != '0)) begin
            if (branch_consumer) begin
                if (ex_hit) begin
                    need = ex_memread ? 2'd2 : 2'd1;
                end else if (mem_load_hit) begin
                    need = 2'd1;
                end
            end else if (ex_hit && ex_memread) begin
                need = 2'd1;
            end
        end
    end

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage early branch resolution: PC source, comparator forwarding,
// stall/bubble/flush control and saturating performance counters.
module id_branch_hazard_ctrl
    import id_branch_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        br_type,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              cmp_eq,
    output logic [1:0]        forbranchA,
    output logic [1:0]        forbranchB,
    output logic [1:0]        PCsrc,
    output logic              stall,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    state_e            state_q;
    logic [CNT_W-1:0]  stall_cycles_q;
    logic [CNT_W-1:0]  flush_count_q;

    logic              is_beq, is_bne, is_jr, is_jump;
    logic              branch_consumer;
    logic [1:0]        src_read;
    logic [REG_AW-1:0] src_addr [2];
    logic [1:0]        need;
    pcsrc_e            pc_sel;
    logic              stall_sel;
    logic              flush_sel;

    assign is_beq  = (br_type == BR_BEQ);
    assign is_bne  = (br_type == BR_BNE);
    assign is_jr   = (br_type == BR_JR);
    assign is_jump = (br_type == BR_J) || (br_type == BR_JAL);

    // Branches and JR name their own operands; uses_rs/uses_rt only describe
    // non-branch consumers.
    assign branch_consumer = is_beq || is_bne || is_jr;
    assign src_read[0]     = branch_consumer ? 1'b1 : uses_rs;
    assign src_read[1]     = branch_consumer ? (is_beq || is_bne) : uses_rt;
    assign src_addr[0]     = id_rs;
    assign src_addr[1]     = id_rt;

    // Per-operand hazard depth and comparator forwarding select
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [1:0] need;
        fwd_e       sel;

        hazard_need_calc #(.REG_AW(REG_AW)) u_need (
            .src_read        (src_read[gi]),
            .branch_consumer (branch_consumer),
            .src             (src_addr[gi]),
            .ex_regwrite     (ex_regwrite),
            .ex_memread      (ex_memread),
            .ex_rd           (ex_rd),
            .mem_regwrite    (mem_regwrite),
            .mem_memread     (mem_memread),
            .mem_rd          (mem_rd),
            .need            (need)
        );

        // MEM ALU result beats the WB value; $0 is always read from the bank
        always_comb begin
            sel = FWD_REG;
            if (src_addr[gi] != '0) begin
                if (mem_regwrite && !mem_memread && (mem_rd == src_addr[gi])) begin
                    sel = FWD_EXOUT;
                end else if (wb_regwrite && (wb_rd == src_addr[gi])) begin
                    sel = FWD_WB;
                end
            end
        end
    end

    assign need = (g_src[0].need > g_src[1].need) ? g_src[0].need : g_src[1].need;

    // Same-cycle decision for the instruction sitting in ID
    always_comb begin
        stall_sel = 1'b0;
        flush_sel = 1'b0;
        pc_sel    = PC_SEQ;
        if (rst_n) begin
            if ((state_q == ST_HOLD) || (need != 2'd0)) begin
                stall_sel = 1'b1;
            end else begin
                if (is_jump) begin
                    pc_sel = PC_JUMP;
                end else if ((is_beq && cmp_eq) || (is_bne && !cmp_eq)) begin
                    pc_sel = PC_BRANCH;
                end else if (is_jr) begin
                    pc_sel = PC_REG;
                end
                flush_sel = (pc_sel != PC_SEQ);
            end
        end
    end

    assign stall        = stall_sel;
    assign bubble_idex  = stall_sel;
    assign flush_ifid   = flush_sel;
    assign PCsrc        = pc_sel;
    assign forbranchA   = rst_n ? g_src[0].sel : FWD_REG;
    assign forbranchB   = rst_n ? g_src[1].sel : FWD_REG;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

    // RUN -> HOLD only for a two-cycle hazard; HOLD always lasts one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  state_q <= (need == 2'd2) ? ST_HOLD : ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Saturating stall and redirect counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_sel && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_sel && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// Self-checking bench for id_branch_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the branch hazard rules.
module tb_id_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  br_type;
    logic        uses_rs, uses_rt;
    logic [4:0]  id_rs, id_rt;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite, mem_memread;
    logic [4:0]  mem_rd;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic        cmp_eq;
    logic [1:0]  forbranchA, forbranchB, PCsrc;
    logic        stall, bubble_idex, flush_ifid;
    logic [15:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    id_branch_hazard_ctrl #(.CNT_W(16), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .br_type(br_type), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .cmp_eq(cmp_eq),
        .forbranchA(forbranchA), .forbranchB(forbranchB), .PCsrc(PCsrc), .stall(stall),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] pc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] need;
    } exp_t;

    bit m_hold  = 1'b0;   // second bubble of a load feeding a branch is owed
    int m_stall = 0;
    int m_flush = 0;

    // Cycles until register r is reachable by the consumer in ID
    function automatic int cycles_until_ready(bit branch, int r);
        int wait_c = 0;
        if (r == 0) return 0;
        if (ex_regwrite && ex_rd == r) begin
            if (branch) wait_c = ex_memread ? 2 : 1;
            else        wait_c = ex_memread ? 1 : 0;
        end
        if (branch && mem_regwrite && mem_memread && mem_rd == r && wait_c < 1) wait_c = 1;
        return wait_c;
    endfunction

    function automatic int fwd_of(int r);
        if (r == 0) return 0;
        if (mem_regwrite && !mem_memread && mem_rd == r) return 2;
        if (wb_regwrite && wb_rd == r) return 1;
        return 0;
    endfunction

    function automatic exp_t model_exp();
        exp_t e = '0;
        bit branch, rd_a, rd_b, taken;
        int na, nb, n;
        branch = (br_type == 1) || (br_type == 2) || (br_type == 5);
        rd_a   = branch ? 1'b1 : uses_rs;
        rd_b   = branch ? (br_type == 1 || br_type == 2) : uses_rt;
        na     = rd_a ? cycles_until_ready(branch, int'(id_rs)) : 0;
        nb     = rd_b ? cycles_until_ready(branch, int'(id_rt)) : 0;
        n      = (na > nb) ? na : nb;
        e.need = 2'(n);
        if (!rst_n) return e;
        e.fa = 2'(fwd_of(int'(id_rs)));
        e.fb = 2'(fwd_of(int'(id_rt)));
        if (m_hold || n > 0) begin
            e.stall = 1'b1;
        end else begin
            taken = (br_type == 1 && cmp_eq) || (br_type == 2 && !cmp_eq);
            if (br_type == 3 || br_type == 4) e.pc = 2'b01;
            else if (taken)                   e.pc = 2'b10;
            else if (br_type == 5)            e.pc = 2'b11;
            e.flush = (e.pc != 2'b00);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model_exp();
        if (!rst_n) begin
            m_hold  <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_hold <= !m_hold && (e.need == 2'd2);
            if (e.stall && m_stall < 65535) m_stall <= m_stall + 1;
            if (e.flush && m_flush < 65535) m_flush <= m_flush + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        br_type = 3'd0; uses_rs = 1'b0; uses_rt = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; cmp_eq = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        br_type = 3'd5; id_rs = 5'd6; mem_regwrite = 1'b1; mem_rd = 5'd6;
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_checks++; if (PCsrc !== 2'b00) begin n_fail++; $display("FAIL reset_pcsrc got %b want 00", PCsrc); end
        n_checks++; if (forbranchA !== 2'b00) begin n_fail++; $display("FAIL reset_fwdA got %b want 00", forbranchA); end
        n_checks++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
        tick();
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        n_checks++; if ({stall, bubble_idex, flush_ifid} !== 3'b000) begin n_fail++; $display("FAIL reset_idle got %b want 000", {stall, bubble_idex, flush_ifid}); end
        $display("test_reset done");
    endtask

    task automatic test_beq_alu_fwd();
        do_reset();
        br_type = 3'd1; id_rs = 5'd3; id_rt = 5'd4; ex_regwrite = 1'b1; ex_rd = 5'd3;
        @(negedge clk);
        n_checks++; if ({stall, bubble_idex, PCsrc} !== 4'b1100) begin n_fail++; $display("FAIL beq_stall got %b want 1100", {stall, bubble_idex, PCsrc}); end
        tick();
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd3; cmp_eq = 1'b1;
        @(negedge clk);
        n_checks++; if (forbranchA !== 2'b10) begin n_fail++; $display("FAIL beq_fwdA got %b want 10", forbranchA); end
        n_checks++; if ({stall, PCsrc, flush_ifid} !== 4'b0101) begin n_fail++; $display("FAIL beq_taken got %b want 0101", {stall, PCsrc, flush_ifid}); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (flush_count !== 16'd1) begin n_fail++; $display("FAIL beq_flushcnt got %0d want 1", flush_count); end
        n_checks++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL beq_stallcnt got %0d want 1", stall_cycles); end
        $display("test_beq_alu_fwd done");
    endtask

    task automatic test_bne_load();
        do_reset();
        br_type = 3'd2; id_rs = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bne_run_stall got %b want 1", stall); end
        tick();
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd5;
        @(negedge clk);
        n_checks++; if ({stall, bubble_idex} !== 2'b11) begin n_fail++; $display("FAIL bne_hold_stall got %b want 11", {stall, bubble_idex}); end
        tick();
        mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
        wb_regwrite = 1'b1; wb_rd = 5'd5; cmp_eq = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL bne_stallcnt got %0d want 2", stall_cycles); end
        n_checks++; if (forbranchA !== 2'b01) begin n_fail++; $display("FAIL bne_fwdA got %b want 01", forbranchA); end
        n_checks++; if ({stall, PCsrc, flush_ifid} !== 4'b0101) begin n_fail++; $display("FAIL bne_taken got %b want 0101", {stall, PCsrc, flush_ifid}); end
        $display("test_bne_load done");
    endtask

    task automatic test_jr_zero();
        do_reset();
        br_type = 3'd5; id_rs = 5'd0; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0;
        mem_regwrite = 1'b1; mem_rd = 5'd0;
        @(negedge clk);
        n_checks++; if ({stall, forbranchA} !== 3'b000) begin n_fail++; $display("FAIL jr_zero_nostall got %b want 000", {stall, forbranchA}); end
        n_checks++; if ({PCsrc, flush_ifid} !== 3'b111) begin n_fail++; $display("FAIL jr_redirect got %b want 111", {PCsrc, flush_ifid}); end
        $display("test_jr_zero done");
    endtask

    task automatic test_alu_consumer();
        do_reset();
        uses_rs = 1'b1; id_rs = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL add_loaduse got %b want 1", stall); end
        tick();
        ex_memread = 1'b0;
        @(negedge clk);
        n_checks++; if ({stall, PCsrc, flush_ifid} !== 4'b0000) begin n_fail++; $display("FAIL add_alu_nostall got %b want 0000", {stall, PCsrc, flush_ifid}); end
        tick();
        ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd7;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL add_memload_nostall got %b want 0", stall); end
        $display("test_alu_consumer done");
    endtask

    task automatic test_priority_and_jump();
        do_reset();
        br_type = 3'd1; id_rs = 5'd9; id_rt = 5'd9; cmp_eq = 1'b0;
        mem_regwrite = 1'b1; mem_rd = 5'd9; wb_regwrite = 1'b1; wb_rd = 5'd9;
        @(negedge clk);
        n_checks++; if ({forbranchA, forbranchB} !== 4'b1010) begin n_fail++; $display("FAIL mem_over_wb got %b want 1010", {forbranchA, forbranchB}); end
        n_checks++; if ({stall, PCsrc, flush_ifid} !== 4'b0000) begin n_fail++; $display("FAIL beq_not_taken got %b want 0000", {stall, PCsrc, flush_ifid}); end
        tick();
        br_type = 3'd3;
        @(negedge clk);
        n_checks++; if ({PCsrc, flush_ifid} !== 3'b011) begin n_fail++; $display("FAIL j_redirect got %b want 011", {PCsrc, flush_ifid}); end
        $display("test_priority_and_jump done");
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        br_type = 3'd2; id_rs = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        tick();
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_before_reset got %b want 1", stall); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({stall, bubble_idex, flush_ifid} !== 3'b000) begin n_fail++; $display("FAIL hold_reset_forced got %b want 000", {stall, bubble_idex, flush_ifid}); end
        tick();
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_reset_run got %b want 0", stall); end
        n_checks++; if ({stall_cycles, flush_count} !== 32'd0) begin n_fail++; $display("FAIL hold_reset_cnt got %h want 0", {stall_cycles, flush_count}); end
        $display("test_reset_in_hold done");
    endtask

    task automatic test_random();
        exp_t e;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick();
            rst_n        = ($urandom_range(0, 24) != 0);
            br_type      = 3'($urandom_range(0, 7));
            uses_rs      = 1'($urandom);
            uses_rt      = 1'($urandom);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom);
            ex_memread   = 1'($urandom);
            ex_rd        = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom);
            mem_memread  = 1'($urandom);
            mem_rd       = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom);
            wb_rd        = 5'($urandom_range(0, 3));
            cmp_eq       = 1'($urandom);
            @(negedge clk);
            e = model_exp();
            n_checks++;
            if ({stall, bubble_idex, flush_ifid, PCsrc, forbranchA, forbranchB} !==
                {e.stall, e.stall, e.flush, e.pc, e.fa, e.fb}) begin
                n_fail++; bad++;
                $display("FAIL rand_ctrl[%0d] got s%b b%b f%b pc%b A%b B%b want s%b b%b f%b pc%b A%b B%b", i,
                         stall, bubble_idex, flush_ifid, PCsrc, forbranchA, forbranchB,
                         e.stall, e.stall, e.flush, e.pc, e.fa, e.fb);
            end
            n_checks++;
            if ({stall_cycles, flush_count} !== {16'(m_stall), 16'(m_flush)}) begin
                n_fail++; bad++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cycles, flush_count, m_stall, m_flush);
            end
        end
        rst_n = 1'b1;
        $display("test_random done, %0d bad cycles", bad);
    endtask

    task automatic test_saturation();
        do_reset();
        uses_rs = 1'b1; id_rs = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        n_checks++; if (stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near got %h want fffe", stall_cycles); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", stall_cycles); end
        $display("test_saturation done");
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_beq_alu_fwd();
        test_bne_load();
        test_jr_zero();
        test_alu_consumer();
        test_priority_and_jump();
        test_reset_in_hold();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_branch_hazard_ctrl.md
Name: id_branch_hazard_ctrl

Overview:
- Sequencer for the ID stage's early branch resolution in the 5-stage MIPS pipeline.
- Decides branch/jump PC source, selects the two ID-stage operand forwarding muxes, and inserts stalls when an operand is not yet available.
- Flushes IF/ID on redirect and keeps saturating performance counters.
- Sits beside the ID stage; drives its forbranchA, forbranchB and PCsrc selects, plus pipeline-register stall/flush enables.

Parameters:
CNT_W, 16, width of the stall and flush performance counters
REG_AW, 5, register-address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
br_type  in  3  ID instruction class: 0 NONE, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR; 6-7 treated as NONE
uses_rs  in  1  ID instruction reads rs (non-branch consumers)
uses_rt  in  1  ID instruction reads rt (non-branch consumers)
id_rs  in  REG_AW  rs address of ID instruction
id_rt  in  REG_AW  rt address of ID instruction
ex_regwrite  in  1  EX-stage instruction writes a register
ex_memread  in  1  EX-stage instruction is a load
ex_rd  in  REG_AW  EX-stage destination
mem_regwrite  in  1  MEM-stage instruction writes a register
mem_memread  in  1  MEM-stage instruction is a load
mem_rd  in  REG_AW  MEM-stage destination
wb_regwrite  in  1  WB-stage writes the register bank
wb_rd  in  REG_AW  WB-stage destination
cmp_eq  in  1  ID comparator result on the forwarded operands
forbranchA  out  2  rs operand select: 00 regfile, 01 writeData (WB), 10 exOut (MEM ALU result), 11 zero
forbranchB  out  2  rt operand select, same encoding
PCsrc  out  2  00 pc+4, 01 jump target, 10 branch target, 11 rs register
stall  out  1  hold PC and IF/ID
bubble_idex  out  1  load a NOP into ID/EX
flush_ifid  out  1  zero IF/ID on the next edge
stall_cycles  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- Register $0 is never a hazard or forward source. Any address equal to 0 is ignored for hazard and forwarding decisions.
- Branch consumers: BEQ/BNE read rs and rt; JR reads rs. For these, uses_rs and uses_rt are ignored.
- need (combinational) is the maximum over the read source registers r:
  - Branch or JR consumer: EX load writing r gives 2; EX non-load writing r gives 1; MEM load writing r gives 1; otherwise 0.
  - Any other consumer: EX load writing r gives 1; otherwise 0.
- FSM states RUN and HOLD.
- RUN, need=0 (no stall):
  - stall=0 and bubble_idex=0.
  - Branch taken = (BEQ & cmp_eq) | (BNE & ~cmp_eq).
  - PCsrc = 01 for J/JAL, 10 for a taken branch, 11 for JR, 00 otherwise.
  - flush_ifid=1 exactly when PCsrc≠00.
- RUN, need≥1:
  - stall=1, bubble_idex=1, PCsrc=00, flush_ifid=0.
  - cmp_eq is ignored.
  - If need=2, next state is HOLD; otherwise stay in RUN and re-evaluate on the next cycle.
- HOLD:
  - stall=1, bubble_idex=1, PCsrc=00, flush_ifid=0; all pipeline inputs are ignored.
  - Always returns to RUN after one cycle.
- Forwarding: forbranchA and forbranchB are combinational in every state.
  - MEM non-load writing r selects 10.
  - Otherwise WB writing r selects 01.
  - Otherwise 00.
  - MEM has priority over WB; 11 is never driven.
- Counters:
  - stall_cycles increments on every cycle with stall=1.
  - flush_count increments on every cycle with flush_ifid=1.
  - Both saturate at all-ones and do not wrap.
- Reset (rst_n=0 at a rising edge; checked mid-HOLD as well):
  - State becomes RUN and counters clear to 0.
  - While rst_n=0, the outputs are forced: stall=0, bubble_idex=0, flush_ifid=0, PCsrc=00, forbranchA=00, forbranchB=00.
- Latency: decisions for the instruction in ID appear in the same cycle (combinational). FSM and counters update at the edge.

Decomposition:
- Shared package holds:
  - br_type encodings;
  - PCsrc encodings;
  - forwarding select encodings (FWD_REG, FWD_WB, FWD_EXOUT, FWD_ZERO);
  - FSM state typedef.
- One natural sub-module, hazard_need_calc: the combinational computation of need for a single source register. It is instantiated twice (rs, rt); the parent takes the maximum.

Test Plan:
- BEQ rs=3 rt=4; EX add writes 3, non-load → cycle 0: stall=1, bubble=1, PCsrc=00. Next cycle the add is in MEM: forbranchA=10, stall=0. With cmp_eq=1: PCsrc=10, flush_ifid=1, flush_count=1.
- BNE rs=5; EX lw writes 5 → stall for 2 cycles (RUN then HOLD), stall_cycles=2. Third cycle with lw in WB: forbranchA=01. With cmp_eq=0: PCsrc=10.
- JR rs=0; EX writes 0 → no stall, forbranchA=00, PCsrc=11, flush_ifid=1.
- ADD (uses_rs, rs=7); EX lw writes 7 → one stall cycle. ALU producer in EX writing 7 → no stall.
- MEM and WB both write 9, MEM non-load; BEQ rs=9 → forbranchA=10 (MEM wins). J → PCsrc=01, flush_ifid=1.
- rst_n=0 during HOLD → next cycle state RUN, stall=0, counters 0. Force 65536 stall cycles → stall_cycles holds 0xFFFF.
